// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI FSM states, default frame width and mode encodings
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } spi_state_e;

  localparam int SPI_DATA_W_DEF = 8;

  // Mode encodings as {cpol, cpha}, shared with the clock/flag generator
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - SPI frame shifter: drives mosi, captures miso on generator strobes
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              lsbfe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              flag_low,
  input  logic              flag_high,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              busy,
  output logic              rx_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  spi_state_e        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              m_cpol;
  logic              m_cpha;
  logic              m_lsbfe;

  logic              strb;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  cnt_next;

  // Bit of word w to transmit after idx bits have already gone out
  function automatic logic tx_bit(input logic [DATA_W-1:0] w,
                                  input logic [CNT_W-1:0]  idx,
                                  input logic              lsb_first);
    logic [CNT_W-1:0]  pos;
    logic [DATA_W-1:0] shifted;
    pos     = lsb_first ? idx : (LAST_CNT - CNT_W'(1) - idx);
    shifted = w >> pos;
    return shifted[0];
  endfunction

  // Pick the sampling strobe for the mode latched at load; the other flag is ignored
  always_comb begin
    strb = flag_low;
    case ({m_cpol, m_cpha})
      MODE0, MODE3: strb = flag_low;
      MODE1, MODE2: strb = flag_high;
      default:      strb = flag_low;
    endcase
  end

  // Receive shift and bit count as they would look after this strobe
  always_comb begin
    rx_next  = m_lsbfe ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
    cnt_next = bit_cnt + CNT_W'(1);
  end

  // Frame FSM: load, sample on strobe, advance mosi one cycle later, publish word
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      m_cpol    <= 1'b0;
      m_cpha    <= 1'b0;
      m_lsbfe   <= 1'b0;
      mosi      <= 1'b0;
      data_miso <= '0;
      busy      <= 1'b0;
      rx_done   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_data && !ss) begin
            tx_sr   <= data_mosi;
            mosi    <= tx_bit(data_mosi, '0, lsbfe);
            bit_cnt <= '0;
            m_cpol  <= cpol;
            m_cpha  <= cpha;
            m_lsbfe <= lsbfe;
            busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss) begin
            // Abort beats a coincident strobe: the sampled bit is dropped
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else if (strb) begin
            rx_sr   <= rx_next;
            bit_cnt <= cnt_next;
            if (cnt_next == LAST_CNT) begin
              data_miso <= rx_next;
              rx_done   <= 1'b1;
              state     <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (ss) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
          end else begin
            mosi  <= tx_bit(tx_sr, bit_cnt, m_lsbfe);
            state <= ACTIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          mosi  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_reg.sv
// tb/tb_spi_shift_reg.sv - randomized self-checking bench for spi_shift_reg
module tb_spi_shift_reg;

  logic       PCLK;
  logic       PRESETn;
  logic       ss;
  logic       send_data;
  logic [7:0] data_mosi;
  logic       lsbfe;
  logic       cpol;
  logic       cpha;
  logic       flag_low;
  logic       flag_high;
  logic       miso;
  logic       mosi;
  logic [7:0] data_miso;
  logic       busy;
  logic       rx_done;

  int         checks;
  int         errors;
  int         rx_pulses;
  logic [7:0] last_rx;

  spi_shift_reg #(.DATA_W(8)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .ss        (ss),
    .send_data (send_data),
    .data_mosi (data_mosi),
    .lsbfe     (lsbfe),
    .cpol      (cpol),
    .cpha      (cpha),
    .flag_low  (flag_low),
    .flag_high (flag_high),
    .miso      (miso),
    .mosi      (mosi),
    .data_miso (data_miso),
    .busy      (busy),
    .rx_done   (rx_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Count every clock cycle that rx_done is seen high
  always @(posedge PCLK) if (rx_done === 1'b1) rx_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  function automatic bit uses_high(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  task automatic set_flag(input bit high, input logic v);
    if (high) flag_high = v;
    else      flag_low  = v;
  endtask

  // One frame; stop_kind 0 = runs to end, 1 = ss abort with a strobe, 2 = PRESETn pulse
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] rxw, input logic l,
                           input logic [1:0] mode, input int stop_kind, input int stop_at,
                           input bit mid_send, input bit both_flags);
    logic seq [8];
    int   p0;
    bit   hi;
    hi = uses_high(mode);
    for (int i = 0; i < 8; i++) seq[i] = l ? tx[i] : tx[7-i];
    cpol = mode[1]; cpha = mode[0]; lsbfe = l;
    data_mosi = tx; ss = 1'b0; send_data = 1'b1;
    p0 = rx_pulses;
    tick;
    send_data = 1'b0;
    data_mosi = 8'($urandom);
    cpol  = 1'($urandom);
    cpha  = 1'($urandom);
    lsbfe = 1'($urandom);
    check("busy_load", busy, 1);
    check("mosi_first", mosi, seq[0]);
    for (int i = 0; i < 8; i++) begin
      miso = l ? rxw[i] : rxw[7-i];
      if (stop_kind == 1 && stop_at == i) begin
        ss = 1'b1;
        set_flag(hi, 1'b1);
        tick;
        set_flag(hi, 1'b0);
        check("abort_busy", busy, 0);
        check("abort_mosi", mosi, 0);
        tick;
        tick;
        ss = 1'b0;
        check("abort_hold_rx", data_miso, last_rx);
        check("abort_no_done", rx_pulses, p0);
        return;
      end
      if (stop_kind == 2 && stop_at == i) begin
        PRESETn = 1'b0;
        #1;
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_data_miso", data_miso, 0);
        last_rx = 8'h00;
        tick;
        PRESETn = 1'b1;
        tick;
        return;
      end
      set_flag(hi, 1'b1);
      if (both_flags) set_flag(!hi, 1'b1);
      tick;
      flag_low = 1'b0; flag_high = 1'b0;
      miso = 1'($urandom);
      if (i < 7) begin
        check("no_early_done", rx_done, 0);
        if (mid_send && i == 3) begin
          data_mosi = 8'h00;
          send_data = 1'b1;
        end
        set_flag(!hi, 1'b1);
        tick;
        send_data = 1'b0;
        set_flag(!hi, 1'b0);
        check("mosi_bit", mosi, seq[i+1]);
        set_flag(!hi, 1'b1);
        tick;
        set_flag(!hi, 1'b0);
        check("busy_mid", busy, 1);
      end else begin
        check("rx_done_pulse", rx_done, 1);
        check("data_miso", data_miso, rxw);
        check("mosi_hold_last", mosi, seq[7]);
        last_rx = rxw;
        tick;
        check("rx_done_clear", rx_done, 0);
        check("busy_end", busy, 0);
        check("mosi_end", mosi, 0);
        check("one_pulse", rx_pulses, p0 + 1);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; rx_pulses = 0; last_rx = 8'h00;
    PRESETn = 1'b0; ss = 1'b1; send_data = 1'b0; data_mosi = 8'h00;
    lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0;
    flag_low = 1'b0; flag_high = 1'b0; miso = 1'b0;
    #12;
    check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_data_miso", data_miso, 0);
    tick;
    PRESETn = 1'b1;
    tick;

    // send_data with slave deselected must not start a frame
    ss = 1'b1; data_mosi = 8'hFF; send_data = 1'b1;
    tick;
    send_data = 1'b0;
    check("ss_high_ignored", busy, 0);
    tick;

    run_frame(8'hA5, 8'h3C, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    run_frame(8'hA5, 8'h3C, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    run_frame(8'h5A, 8'h3C, 1'b0, 2'b01, 0, 0, 1'b0, 1'b1);
    run_frame(8'hFF, 8'h81, 1'b0, 2'b00, 1, 3, 1'b0, 1'b0);
    run_frame(8'hA5, 8'h96, 1'b0, 2'b00, 0, 0, 1'b1, 1'b0);
    run_frame(8'hC3, 8'h7E, 1'b1, 2'b11, 2, 4, 1'b0, 1'b0);
    run_frame(8'h81, 8'hE7, 1'b0, 2'b10, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int k;
      k = int'($urandom_range(0, 5));
      run_frame(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                (k < 4) ? 0 : k - 3, int'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom));
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
